// File: rtl/bsr_meta_pkg.sv
// Types and defaults shared by the metadata responder, the sparse scheduler and the DMA meta loader.
package bsr_meta_pkg;

  localparam int META_DATA_W          = 32;
  localparam int META_DEPTH_DEFAULT   = 512;
  localparam int COL_IDX_BASE_DEFAULT = 256;
  localparam int RSP_DEPTH_DEFAULT    = 2;

  typedef struct packed {
    logic                   oor;
    logic [META_DATA_W-1:0] data;
  } meta_rsp_t;

endpackage

// File: rtl/meta_rsp_fifo.sv
// Synchronous response FIFO, registered head, no fall-through; push on full is legal only with a pop.
// Reset and flush empty it in one edge; storage itself is never cleared.
module meta_rsp_fifo
  import bsr_meta_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  meta_rsp_t              push_dat_i,
  input  logic                   pop_i,
  output logic                   out_vld_o,
  output meta_rsp_t              out_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  meta_rsp_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign out_vld_o = (count_q != '0);
  assign out_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/bsr_meta_responder.sv
// Metadata BRAM owner serving in-order scheduler reads: accept edge N -> rvalid after edge N+1.
// A request is accepted only while queued + in-flight responses leave a free queue slot.
module bsr_meta_responder
  import bsr_meta_pkg::*;
#(
  parameter int DEPTH        = META_DEPTH_DEFAULT,
  parameter int DATA_W       = META_DATA_W,
  parameter int COL_IDX_BASE = COL_IDX_BASE_DEFAULT,
  parameter int RSP_DEPTH    = RSP_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              meta_raddr,
  input  logic                     meta_ren,
  output logic                     meta_req_ready,
  output logic [DATA_W-1:0]        meta_rdata,
  output logic                     meta_rvalid,
  input  logic                     meta_ready,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     oor_err,
  output logic [31:0]              rd_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  if (COL_IDX_BASE >= DEPTH) begin : g_bad_col_base
    $error("bsr_meta_responder: COL_IDX_BASE must be below DEPTH");
  end
  if ((RSP_DEPTH < 2) || ((RSP_DEPTH & (RSP_DEPTH - 1)) != 0)) begin : g_bad_rsp_depth
    $error("bsr_meta_responder: RSP_DEPTH must be a power of 2 and at least 2");
  end
  if (DATA_W != META_DATA_W) begin : g_bad_data_w
    $error("bsr_meta_responder: DATA_W must match the shared response type");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_dat_q;
  logic              inflight_q, inflight_d;
  logic              rd_oor_q, rd_oor_d;
  logic              oor_err_q, oor_err_d;
  logic [31:0]       rd_count_q, rd_count_d;
  logic [CW-1:0]     q_count;
  logic              accept, addr_oor;
  meta_rsp_t         enq_dat, head_dat;

  // Full-width compare so high garbage bits can never alias into the array.
  assign addr_oor       = (meta_raddr >= 32'(DEPTH));
  assign meta_req_ready = !rst && !flush &&
                          ((32'(q_count) + 32'(inflight_q)) < 32'(RSP_DEPTH));
  assign accept         = meta_ren && meta_req_ready;

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: the registered read sees the array before a same-edge write lands.
  always_ff @(posedge clk) begin
    if (accept) rd_dat_q <= mem[meta_raddr[AW-1:0]];
  end

  always_comb begin
    inflight_d = inflight_q;
    rd_oor_d   = rd_oor_q;
    oor_err_d  = oor_err_q;
    rd_count_d = rd_count_q;
    if (flush) begin
      inflight_d = 1'b0;
      rd_oor_d   = 1'b0;
      oor_err_d  = 1'b0;
      rd_count_d = '0;
    end else begin
      inflight_d = accept;
      rd_oor_d   = accept && addr_oor;
      if (accept && addr_oor) oor_err_d = 1'b1;
      if (accept && (rd_count_q != '1)) rd_count_d = rd_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      oor_err_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_oor_q   <= rd_oor_d;
      oor_err_q  <= oor_err_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign enq_dat.oor  = rd_oor_q;
  assign enq_dat.data = rd_dat_q;

  meta_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .push_i    (inflight_q),
    .push_dat_i(enq_dat),
    .pop_i     (meta_ready),
    .out_vld_o (meta_rvalid),
    .out_dat_o (head_dat),
    .count_o   (q_count)
  );

  // Out-of-range responses and an empty queue both present zero data.
  assign meta_rdata = (meta_rvalid && !head_dat.oor) ? head_dat.data : '0;
  assign oor_err    = oor_err_q;
  assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_bsr_meta_responder.sv
// Randomised and directed bench for bsr_meta_responder with a queue-based scoreboard and
// an array model of the metadata store.
module tb_bsr_meta_responder;
  localparam int DEPTH = 512;
  localparam int RSP   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] meta_raddr;
  logic        meta_ren;
  logic        meta_req_ready;
  logic [31:0] meta_rdata;
  logic        meta_rvalid;
  logic        meta_ready;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flush;
  logic        oor_err;
  logic [31:0] rd_count;

  always #5 clk = ~clk;

  bsr_meta_responder dut (
    .clk           (clk),
    .rst           (rst),
    .meta_raddr    (meta_raddr),
    .meta_ren      (meta_ren),
    .meta_req_ready(meta_req_ready),
    .meta_rdata    (meta_rdata),
    .meta_rvalid   (meta_rvalid),
    .meta_ready    (meta_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .flush         (flush),
    .oor_err       (oor_err),
    .rd_count      (rd_count)
  );

  // Each accepted read owes one response, visible from edge number 'vis' onwards.
  typedef struct {
    logic [31:0] d;
    int          vis;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] mm [DEPTH];
  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  bit          started = 0;
  bit          acc_last = 0;
  logic        model_oor = 1'b0;
  logic [31:0] model_cnt = 32'd0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // One clock: check credit/status at the negedge, then commit the model at the posedge.
  task automatic tick();
    bit          acc, rdy_m;
    logic [31:0] exp_d;
    @(negedge clk);
    rdy_m = !rst && !flush && (sbq.size() < RSP);
    if (started) begin
      chk("req_ready", 32'(meta_req_ready), 32'(rdy_m));
      chk("oor_err", 32'(oor_err), 32'(model_oor));
      chk("rd_count", rd_count, model_cnt);
    end
    acc   = meta_ren && rdy_m;
    exp_d = (meta_raddr < DEPTH) ? mm[meta_raddr[8:0]] : 32'h0;
    @(posedge clk);
    if (rst) begin
      sbq.delete();
      model_oor = 1'b0;
      model_cnt = 32'd0;
      started   = 1'b1;
      acc       = 1'b0;
    end else begin
      if (wr_en) mm[wr_addr] = wr_data;
      if (flush) begin
        sbq.delete();
        model_oor = 1'b0;
        model_cnt = 32'd0;
      end else if (acc) begin
        sbq.push_back('{d: exp_d, vis: cyc_n + 2});
        if (meta_raddr >= DEPTH) model_oor = 1'b1;
        if (model_cnt != 32'hffff_ffff) model_cnt++;
      end
    end
    acc_last = acc;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 9'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a);
    meta_ren = 1'b1; meta_raddr = a;
    tick();
    for (int i = 0; i < 40 && !acc_last; i++) tick();
    if (!acc_last) begin
      total++; bad++;
      $display("FAIL issue_timeout: read of %0h never accepted", a);
    end
    meta_ren = 1'b0;
  endtask

  // Monitor: compares the head while valid; a pop retires the scoreboard entry at the next edge.
  initial begin : monitor
    bit popq, ev;
    forever begin
      @(negedge clk);
      popq = 1'b0;
      if (started && !rst && !flush) begin
        ev = (sbq.size() > 0) && (sbq[0].vis <= cyc_n);
        chk("rvalid", 32'(meta_rvalid), 32'(ev));
        if (ev && (meta_rvalid === 1'b1)) begin
          chk("rdata", meta_rdata, sbq[0].d);
          popq = meta_ready;
        end
      end
      @(posedge clk);
      if (popq) void'(sbq.pop_front());
    end
  end

  initial begin : stim
    rst = 1'b1; meta_raddr = '0; meta_ren = 1'b0; meta_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0;
    idle(2);
    chk("rst_rvalid", 32'(meta_rvalid), 32'd0);
    chk("rst_rdata", meta_rdata, 32'd0);
    chk("rst_req_ready", 32'(meta_req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(meta_req_ready), 32'd1);
    chk("post_rst_rd_count", rd_count, 32'd0);

    for (int i = 0; i < DEPTH; i++) wr(i, $urandom());

    // Basic reads and two-edge latency
    wr(0, 32'd0); wr(1, 32'd3); wr(256, 32'd7);
    issue(1);
    chk("t1_rvalid_edge1", 32'(meta_rvalid), 32'd0);
    tick();
    chk("t1_rvalid_edge2", 32'(meta_rvalid), 32'd1);
    chk("t1_rdata", meta_rdata, 32'd3);
    issue(256);
    idle(4);

    // Stalled consumer: two accepts fill the credit, third waits
    meta_ready = 1'b0; meta_ren = 1'b1; meta_raddr = 32'd0;
    tick();
    meta_raddr = 32'd1;
    tick();
    meta_raddr = 32'd256;
    idle(3);
    chk("t2_req_held", 32'(meta_req_ready), 32'd0);
    chk("t2_head", meta_rdata, 32'd0);
    meta_ready = 1'b1;
    tick();
    for (int i = 0; i < 20 && !acc_last; i++) tick();
    if (!acc_last) begin
      total++; bad++;
      $display("FAIL t2_timeout: third read never accepted");
    end
    meta_ren = 1'b0;
    idle(4);

    // Same-edge write and read: old data returned, new data afterwards
    wr(5, 32'd7);
    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'd9; meta_ren = 1'b1; meta_raddr = 32'd5;
    tick();
    wr_en = 1'b0; meta_ren = 1'b0;
    tick();
    chk("t3_read_first", meta_rdata, 32'd7);
    issue(5);
    idle(4);

    // Out-of-range reads, sticky error, flush clears it
    issue(32'd512);
    issue(32'h8000_0003);
    issue(32'd1);
    idle(3);
    chk("t4_oor_sticky", 32'(oor_err), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t4_oor_cleared", 32'(oor_err), 32'd0);

    // Flush with one queued and one in flight
    meta_ready = 1'b0; meta_ren = 1'b1; meta_raddr = 32'd1;
    tick();
    meta_raddr = 32'd256;
    tick();
    meta_ren = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t5_rvalid", 32'(meta_rvalid), 32'd0);
    chk("t5_req_ready", 32'(meta_req_ready), 32'd1);
    chk("t5_rd_count", rd_count, 32'd0);
    meta_ready = 1'b1;
    idle(4);

    // Reset with a full queue; a write during reset must not land
    meta_ready = 1'b0; meta_ren = 1'b1; meta_raddr = 32'd1;
    tick();
    meta_raddr = 32'd0;
    tick();
    meta_ren = 1'b0;
    idle(2);
    chk("t6_full_rvalid", 32'(meta_rvalid), 32'd1);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 9'd1; wr_data = 32'hdead_beef;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    #1;
    chk("t6_rvalid", 32'(meta_rvalid), 32'd0);
    chk("t6_rdata", meta_rdata, 32'd0);
    chk("t6_req_ready", 32'(meta_req_ready), 32'd1);
    chk("t6_oor", 32'(oor_err), 32'd0);
    meta_ready = 1'b1;
    issue(1);
    tick();
    chk("t6_bram_kept", meta_rdata, 32'd3);
    idle(3);

    // Random traffic with narrow address windows to force collisions
    for (int n = 0; n < 1500; n++) begin
      bit narrow;
      narrow     = ($urandom_range(0, 1) == 0);
      meta_ren   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) meta_raddr = $urandom() | 32'h200;
      else meta_raddr = narrow ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, DEPTH - 1));
      meta_ready = ($urandom_range(0, 3) != 0);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_addr    = narrow ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, DEPTH - 1));
      wr_data    = $urandom();
      flush      = ($urandom_range(0, 59) == 0);
      tick();
    end

    meta_ren = 1'b0; wr_en = 1'b0; flush = 1'b0; meta_ready = 1'b1;
    idle(6);
    chk("drain_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
